// File: rtl/queue_controller_mq_pkg.sv
// Shared definitions for the multi-queue instruction-buffer pointer engine:
// width helper and the bit positions of the sticky error vector.
`ifndef QCM_CLOG2_MIN1
`define QCM_CLOG2_MIN1(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package queue_controller_mq_pkg;

    // Bit positions inside err[2:0]
    localparam int ERR_VT_OVF = 0;
    localparam int ERR_WR_OVR = 1;
    localparam int ERR_RD_UNF = 2;
    localparam int ERR_W      = 3;

    // Queue-id width; a single queue still gets a 1-bit id field.
    function automatic int qid_width(input int n);
        return `QCM_CLOG2_MIN1(n);
    endfunction

endpackage

// File: rtl/queue_controller_mq_if.sv
// Fetch/decode-facing bundle of the queue controller.
// Handshake: every request (vtail_incr, vtail_dec, q_wr, q_rd, q_reset) is a
// single-cycle strobe with no ready; it is accepted on the rising edge it is
// high. Illegal requests are dropped and flagged in err, and buff_wr_en tells
// the buffer RAM whether the q_wr of this cycle is accepted.
interface queue_controller_mq_if #(
    parameter int NUM_Q = 8,
    parameter int DEPTH = 8
);
    import queue_controller_mq_pkg::*;

    localparam int QID_W = qid_width(NUM_Q);
    localparam int AW    = $clog2(DEPTH);

    logic                    vtail_incr;
    logic [QID_W-1:0]        vt_qid;
    logic                    vtail_dec;
    logic [QID_W-1:0]        vd_qid;
    logic                    q_wr;
    logic [QID_W-1:0]        wr_qid;
    logic                    q_rd;
    logic [QID_W-1:0]        rd_qid;
    logic [NUM_Q-1:0]        q_reset;
    logic [NUM_Q-1:0]        q_empty;
    logic [NUM_Q-1:0]        stop_fetch;
    logic [NUM_Q*(AW+1)-1:0] occupancy;
    logic [QID_W+AW-1:0]     buff_rd_addr;
    logic [QID_W+AW-1:0]     buff_wr_addr;
    logic                    buff_wr_en;
    logic [ERR_W-1:0]        err;

    // Fetch/decode side
    modport master (
        output vtail_incr, vt_qid, vtail_dec, vd_qid, q_wr, wr_qid, q_rd, rd_qid, q_reset,
        input  q_empty, stop_fetch, occupancy, buff_rd_addr, buff_wr_addr, buff_wr_en, err
    );

    // Controller side
    modport slave (
        input  vtail_incr, vt_qid, vtail_dec, vd_qid, q_wr, wr_qid, q_rd, rd_qid, q_reset,
        output q_empty, stop_fetch, occupancy, buff_rd_addr, buff_wr_addr, buff_wr_en, err
    );

endinterface

// File: rtl/queue_controller_mq_ptr_slice.sv
// One queue's head/tail/vtail pointers with an extra wrap bit, legality
// checks, status outputs and single-cycle error pulses.
module queue_ptr_slice #(
    parameter int DEPTH       = 8,
    parameter int STOP_MARGIN = 2,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          incr,
    input  logic          dec,
    input  logic          wr,
    input  logic          rd,
    input  logic          flush,
    output logic          empty,
    output logic          stop,
    output logic [AW:0]   occ,
    output logic [AW-1:0] head_idx,
    output logic [AW-1:0] tail_idx,
    output logic          wr_ok,
    output logic          vt_ovf,
    output logic          wr_ovr,
    output logic          rd_unf
);
    localparam int          PW     = AW + 1;
    localparam logic [AW:0] FULL   = PW'(DEPTH);
    localparam logic [AW:0] THRESH = PW'(DEPTH - STOP_MARGIN);

    logic [AW:0] head, tail, vtail;
    logic [AW:0] reserved;
    logic        incr_only, dec_only, incr_ok, dec_ok, rd_ok;

    // Differences are taken mod 2^(AW+1), so they stay correct across the wrap.
    assign reserved = vtail - head;
    assign occ      = tail - head;
    assign empty    = (head == tail);
    assign stop     = (reserved >= THRESH);
    assign head_idx = head[AW-1:0];
    assign tail_idx = tail[AW-1:0];

    // A simultaneous reserve and release cancel out and skip the overflow check.
    assign incr_only = incr & ~dec;
    assign dec_only  = dec & ~incr;
    assign incr_ok   = incr_only & (reserved != FULL);
    assign dec_ok    = dec_only & (vtail != tail);
    assign wr_ok     = wr & (tail != vtail) & ~flush;
    assign rd_ok     = rd & ~empty;

    // A flush swallows every op on this queue, including its error reports.
    assign vt_ovf = incr_only & (reserved == FULL) & ~flush;
    assign wr_ovr = wr & (tail == vtail) & ~flush;
    assign rd_unf = rd & empty & ~flush;

    // Pointer registers; legality is judged on the pre-edge values above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            vtail <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            vtail <= '0;
        end else begin
            if (incr_ok)
                vtail <= vtail + 1'b1;
            else if (dec_ok)
                vtail <= vtail - 1'b1;
            if (wr_ok)
                tail <= tail + 1'b1;
            if (rd_ok)
                head <= head + 1'b1;
        end
    end

endmodule

// File: rtl/queue_controller_mq.sv
// Pointer/flow-control engine for NUM_Q instruction-buffer queues sharing one
// buffer RAM. Decodes queue ids, muxes the RAM addresses and keeps the sticky
// error flags; per-queue state lives in queue_ptr_slice.
module queue_controller_mq
    import queue_controller_mq_pkg::*;
#(
    parameter int NUM_Q       = 8,
    parameter int DEPTH       = 8,
    parameter int STOP_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    queue_controller_mq_if.slave  bus
);
    localparam int QID_W = qid_width(NUM_Q);
    localparam int AW    = $clog2(DEPTH);

    logic [NUM_Q-1:0]        empty_v, stop_v, wr_ok_v, vt_ovf_v, wr_ovr_v, rd_unf_v;
    logic [AW:0]             occ_v      [NUM_Q];
    logic [AW-1:0]           head_idx_v [NUM_Q];
    logic [AW-1:0]           tail_idx_v [NUM_Q];
    logic [NUM_Q*(AW+1)-1:0] occ_flat;
    logic [AW-1:0]           rd_idx, wr_idx;
    logic [ERR_W-1:0]        err_pulse, err_q;

    // Ids at or above NUM_Q match no slice, so such ops fall through silently.
    for (genvar q = 0; q < NUM_Q; q++) begin : g_q
        localparam logic [QID_W-1:0] QID = QID_W'(q);

        queue_ptr_slice #(
            .DEPTH       (DEPTH),
            .STOP_MARGIN (STOP_MARGIN)
        ) u_slice (
            .clk      (clk),
            .rst      (rst),
            .incr     (bus.vtail_incr && (bus.vt_qid == QID)),
            .dec      (bus.vtail_dec && (bus.vd_qid == QID)),
            .wr       (bus.q_wr && (bus.wr_qid == QID)),
            .rd       (bus.q_rd && (bus.rd_qid == QID)),
            .flush    (bus.q_reset[q]),
            .empty    (empty_v[q]),
            .stop     (stop_v[q]),
            .occ      (occ_v[q]),
            .head_idx (head_idx_v[q]),
            .tail_idx (tail_idx_v[q]),
            .wr_ok    (wr_ok_v[q]),
            .vt_ovf   (vt_ovf_v[q]),
            .wr_ovr   (wr_ovr_v[q]),
            .rd_unf   (rd_unf_v[q])
        );
    end

    // Pack occupancy and select the head/tail slot of the addressed queues.
    always_comb begin
        occ_flat = '0;
        rd_idx   = '0;
        wr_idx   = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            occ_flat[q*(AW+1) +: AW+1] = occ_v[q];
            if (bus.rd_qid == QID_W'(q))
                rd_idx = head_idx_v[q];
            if (bus.wr_qid == QID_W'(q))
                wr_idx = tail_idx_v[q];
        end
    end

    // Collect this cycle's error pulses from all queues.
    always_comb begin
        err_pulse             = '0;
        err_pulse[ERR_VT_OVF] = |vt_ovf_v;
        err_pulse[ERR_WR_OVR] = |wr_ovr_v;
        err_pulse[ERR_RD_UNF] = |rd_unf_v;
    end

    // Sticky error flags, cleared only by the global reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= '0;
        else
            err_q <= err_q | err_pulse;
    end

    assign bus.q_empty      = empty_v;
    assign bus.stop_fetch   = stop_v;
    assign bus.occupancy    = occ_flat;
    assign bus.buff_rd_addr = {bus.rd_qid, rd_idx};
    assign bus.buff_wr_addr = {bus.wr_qid, wr_idx};
    assign bus.buff_wr_en   = |wr_ok_v;
    assign bus.err          = err_q;

endmodule
